// File: rtl/memoria_pkg.sv
// memoria_pkg
// Shared definitions for the data-memory responder: default geometry,
// the default value used by the post-reset sweep, and the FSM state type.
package memoria_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam logic [7:0] INIT_VALUE_DEF = 8'h00;

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

endpackage

// File: rtl/memoria_array.sv
// memoria_array
// Plain 2^ADDR_W x DATA_W single-port synchronous storage with a registered
// read port.
//   clock   : rising-edge clock
//   reset_n : async active-low reset, clears only the read register
//   we      : write enable, writes wdata to mem[addr]
//   re      : read enable, loads rdata from mem[addr]
//   addr    : word address shared by read and write
//   wdata   : write data
//   rdata   : registered read data, holds when re is low
module memoria_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage has no reset; its contents come from whoever writes it first.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register is a normal control flop so the read bus starts at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memoria_dados.sv
// memoria_dados
// Data-memory responder for the control unit. After every reset it sweeps
// the whole array to INIT_VALUE, then answers read/write strobes with
// registered data and one-cycle completion pulses.
//   clock      : rising-edge clock
//   reset_n    : async active-low reset
//   rd, we     : read / write strobes, sampled every rising edge
//   endMem     : word address
//   dataInMem  : write data
//   dataOutMem : registered read data
//   dataValid  : pulse, dataOutMem holds a fresh read result
//   writeAck   : pulse, write committed
//   busy       : high while the init sweep runs, requests ignored
//   erroAcesso : pulse, rd and we were asserted together
module memoria_dados
    import memoria_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(INIT_VALUE_DEF)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rd,
    input  logic              we,
    input  logic [ADDR_W-1:0] endMem,
    input  logic [DATA_W-1:0] dataInMem,
    output logic [DATA_W-1:0] dataOutMem,
    output logic              dataValid,
    output logic              writeAck,
    output logic              busy,
    output logic              erroAcesso
);

    state_t            state;
    state_t            nextState;
    logic [ADDR_W-1:0] sweepPtr;

    logic              doRead;
    logic              doWrite;
    logic              doErr;
    logic              arrWe;
    logic              arrRe;
    logic [ADDR_W-1:0] arrAddr;
    logic [DATA_W-1:0] arrWdata;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= nextState;
        end
    end

    // Leave INIT on the same edge that writes the last word.
    always_comb begin
        nextState = state;
        case (state)
            INIT: if (sweepPtr == '1) nextState = IDLE;
            IDLE: nextState = IDLE;
        endcase
    end

    // During INIT the sweep owns the array port and strobes are ignored;
    // in IDLE simultaneous rd/we is an error and touches nothing.
    always_comb begin
        busy     = 1'b0;
        doRead   = 1'b0;
        doWrite  = 1'b0;
        doErr    = 1'b0;
        arrWe    = 1'b0;
        arrRe    = 1'b0;
        arrAddr  = endMem;
        arrWdata = dataInMem;
        case (state)
            INIT: begin
                busy     = 1'b1;
                arrWe    = 1'b1;
                arrAddr  = sweepPtr;
                arrWdata = INIT_VALUE;
            end
            IDLE: begin
                doRead  = rd & ~we;
                doWrite = we & ~rd;
                doErr   = rd & we;
                arrWe   = doWrite;
                arrRe   = doRead;
            end
        endcase
    end

    // Sweep pointer; wraps back to zero as the sweep finishes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sweepPtr <= '0;
        end else if (state == INIT) begin
            sweepPtr <= sweepPtr + 1'b1;
        end
    end

    // Completion pulses line up with the cycle the registered data appears.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dataValid  <= 1'b0;
            writeAck   <= 1'b0;
            erroAcesso <= 1'b0;
        end else begin
            dataValid  <= doRead;
            writeAck   <= doWrite;
            erroAcesso <= doErr;
        end
    end

    memoria_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clock  (clock),
        .reset_n(reset_n),
        .we     (arrWe),
        .re     (arrRe),
        .addr   (arrAddr),
        .wdata  (arrWdata),
        .rdata  (dataOutMem)
    );

endmodule

// File: tb/tb_memoria_dados.sv
// tb_memoria_dados
// Directed bench for memoria_dados: a default-parameter instance driven from
// a vector table plus hand sequences, and a DATA_W=16/ADDR_W=3 instance
// checked for its shorter sweep and custom INIT_VALUE.
module tb_memoria_dados;

    logic       clock;
    logic       reset_n;
    logic       rd;
    logic       we;
    logic [3:0] endMem;
    logic [7:0] dataInMem;
    logic [7:0] dataOutMem;
    logic       dataValid;
    logic       writeAck;
    logic       busy;
    logic       erroAcesso;

    logic        reset16_n;
    logic        rd16;
    logic        we16;
    logic [2:0]  endMem16;
    logic [15:0] dataIn16;
    logic [15:0] dataOut16;
    logic        dataValid16;
    logic        writeAck16;
    logic        busy16;
    logic        erroAcesso16;

    int compared;
    int mismatched;

    typedef struct {
        logic       rd;
        logic       we;
        logic [3:0] addr;
        logic [7:0] din;
        logic       expValid;
        logic       expAck;
        logic       expErr;
        logic [7:0] expDout;
    } vec_t;

    vec_t vecs[$];

    memoria_dados dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd        (rd),
        .we        (we),
        .endMem    (endMem),
        .dataInMem (dataInMem),
        .dataOutMem(dataOutMem),
        .dataValid (dataValid),
        .writeAck  (writeAck),
        .busy      (busy),
        .erroAcesso(erroAcesso)
    );

    memoria_dados #(
        .DATA_W    (16),
        .ADDR_W    (3),
        .INIT_VALUE(16'hBEEF)
    ) dut16 (
        .clock     (clock),
        .reset_n   (reset16_n),
        .rd        (rd16),
        .we        (we16),
        .endMem    (endMem16),
        .dataInMem (dataIn16),
        .dataOutMem(dataOut16),
        .dataValid (dataValid16),
        .writeAck  (writeAck16),
        .busy      (busy16),
        .erroAcesso(erroAcesso16)
    );

    always #5 clock = ~clock;

    function automatic vec_t mkVec(input logic r, input logic w, input logic [3:0] a,
                                   input logic [7:0] d, input logic v, input logic k,
                                   input logic e, input logic [7:0] q);
        vec_t t;
        t.rd = r; t.we = w; t.addr = a; t.din = d;
        t.expValid = v; t.expAck = k; t.expErr = e; t.expDout = q;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input vec_t t);
        rd = t.rd;
        we = t.we;
        endMem = t.addr;
        dataInMem = t.din;
        step();
    endtask

    task automatic checkVec(input string tag, input vec_t t);
        checkOutput({tag, " dataValid"},  32'(dataValid),  32'(t.expValid));
        checkOutput({tag, " writeAck"},   32'(writeAck),   32'(t.expAck));
        checkOutput({tag, " erroAcesso"}, 32'(erroAcesso), 32'(t.expErr));
        checkOutput({tag, " dataOutMem"}, 32'(dataOutMem), 32'(t.expDout));
        checkOutput({tag, " busy"},       32'(busy),       32'(0));
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        clock = 1'b0;
        reset_n = 1'b0;
        reset16_n = 1'b0;
        rd = 1'b0; we = 1'b0; endMem = '0; dataInMem = '0;
        rd16 = 1'b0; we16 = 1'b0; endMem16 = '0; dataIn16 = '0;

        // Vector table: hand cases, then full write/read-back of all addresses.
        vecs.push_back(mkVec(0, 1, 4'h5, 8'hA7, 0, 1, 0, 8'h00));
        vecs.push_back(mkVec(1, 0, 4'h5, 8'h00, 1, 0, 0, 8'hA7));
        vecs.push_back(mkVec(0, 0, 4'h5, 8'h00, 0, 0, 0, 8'hA7));
        vecs.push_back(mkVec(0, 1, 4'h2, 8'h3C, 0, 1, 0, 8'hA7));
        vecs.push_back(mkVec(1, 1, 4'h2, 8'hFF, 0, 0, 1, 8'hA7));
        vecs.push_back(mkVec(1, 0, 4'h2, 8'h00, 1, 0, 0, 8'h3C));
        vecs.push_back(mkVec(0, 0, 4'h0, 8'h00, 0, 0, 0, 8'h3C));
        for (int i = 0; i < 16; i++) begin
            vecs.push_back(mkVec(0, 1, 4'(i), 8'h10 + 8'((i + 1) % 16), 0, 1, 0, 8'h3C));
        end
        for (int i = 0; i < 16; i++) begin
            vecs.push_back(mkVec(1, 0, 4'(i), 8'h00, 1, 0, 0, 8'h10 + 8'((i + 1) % 16)));
        end
        vecs.push_back(mkVec(0, 0, 4'h0, 8'h00, 0, 0, 0, 8'h10));

        step();
        step();
        checkOutput("reset dataOutMem", 32'(dataOutMem), 32'(0));
        checkOutput("reset dataValid",  32'(dataValid),  32'(0));
        checkOutput("reset writeAck",   32'(writeAck),   32'(0));
        checkOutput("reset erroAcesso", 32'(erroAcesso), 32'(0));
        checkOutput("reset busy",       32'(busy),       32'(1));
        checkOutput("reset16 busy",     32'(busy16),     32'(1));
        checkOutput("reset16 dataOut",  32'(dataOut16),  32'(0));

        // Sweep with a read of addr 3 held the whole time.
        rd = 1'b1; endMem = 4'h3;
        reset_n = 1'b1;
        checkOutput("sweep busy at release", 32'(busy), 32'(1));
        for (int i = 1; i <= 15; i++) begin
            step();
            checkOutput($sformatf("sweep busy edge %0d", i), 32'(busy), 32'(1));
            checkOutput($sformatf("sweep dataValid edge %0d", i), 32'(dataValid), 32'(0));
        end
        step();
        checkOutput("sweep end busy", 32'(busy), 32'(0));
        checkOutput("sweep end dataValid", 32'(dataValid), 32'(0));
        step();
        checkOutput("first read dataValid", 32'(dataValid), 32'(1));
        checkOutput("first read data", 32'(dataOutMem), 32'(8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkVec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset pulse in the middle of a write burst.
        rd = 1'b0; we = 1'b1; endMem = 4'h7; dataInMem = 8'h77;
        step();
        checkOutput("burst ack 1", 32'(writeAck), 32'(1));
        endMem = 4'h8; dataInMem = 8'h88;
        step();
        checkOutput("burst ack 2", 32'(writeAck), 32'(1));
        reset_n = 1'b0;
        #1;
        checkOutput("midreset writeAck", 32'(writeAck), 32'(0));
        checkOutput("midreset busy", 32'(busy), 32'(1));
        checkOutput("midreset dataOutMem", 32'(dataOutMem), 32'(0));
        step();
        reset_n = 1'b1;
        endMem = 4'h7;
        checkOutput("resweep busy at release", 32'(busy), 32'(1));
        for (int i = 1; i <= 15; i++) begin
            step();
            checkOutput($sformatf("resweep busy edge %0d", i), 32'(busy), 32'(1));
            checkOutput($sformatf("resweep writeAck edge %0d", i), 32'(writeAck), 32'(0));
            if (i == 15) begin
                we = 1'b0; rd = 1'b1;
            end
        end
        step();
        checkOutput("resweep end busy", 32'(busy), 32'(0));
        applyStimulus(mkVec(1, 0, 4'h7, 8'h00, 1, 0, 0, 8'h00));
        checkVec("post-reset addr7", mkVec(1, 0, 4'h7, 8'h00, 1, 0, 0, 8'h00));
        applyStimulus(mkVec(1, 0, 4'h5, 8'h00, 1, 0, 0, 8'h00));
        checkVec("post-reset addr5", mkVec(1, 0, 4'h5, 8'h00, 1, 0, 0, 8'h00));
        rd = 1'b0;

        // Wide/shallow instance: 8-cycle sweep to BEEF, then read everything.
        rd16 = 1'b1; endMem16 = 3'd0;
        reset16_n = 1'b1;
        checkOutput("p16 busy at release", 32'(busy16), 32'(1));
        for (int i = 1; i <= 7; i++) begin
            step();
            checkOutput($sformatf("p16 busy edge %0d", i), 32'(busy16), 32'(1));
        end
        step();
        checkOutput("p16 sweep end busy", 32'(busy16), 32'(0));
        checkOutput("p16 sweep end dataValid", 32'(dataValid16), 32'(0));
        for (int a = 0; a < 8; a++) begin
            endMem16 = 3'(a);
            step();
            checkOutput($sformatf("p16 read%0d valid", a), 32'(dataValid16), 32'(1));
            checkOutput($sformatf("p16 read%0d data", a), 32'(dataOut16), 32'(16'hBEEF));
        end
        rd16 = 1'b0;
        step();
        checkOutput("p16 valid drops", 32'(dataValid16), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/memoria_dados.md
Name: memoria_dados

Overview:
- Data-memory responder on the control unit's rd/we/endMem/dataInMem/dataOutMem interface.
- Holds 2^ADDR_W words of DATA_W bits.
- Answers read and write strobes with registered data and completion pulses.
- After every reset, sweeps the array to INIT_VALUE before accepting any access.

Parameters:
DATA_W, 8, width of a memory word and of the data buses
ADDR_W, 4, address width; depth = 2^ADDR_W words
INIT_VALUE, 8'h00, value written to every word during the post-reset sweep

Ports:
clock  input  1  system clock, rising edge active
reset_n  input  1  asynchronous active-low reset
rd  input  1  read strobe, sampled on the rising edge of clock
we  input  1  write strobe, sampled on the rising edge of clock
endMem  input  ADDR_W  word address for rd/we
dataInMem  input  DATA_W  write data, sampled with we
dataOutMem  output  DATA_W  registered read data
dataValid  output  1  one-cycle pulse: dataOutMem carries the result of a read
writeAck  output  1  one-cycle pulse: the write has been committed
busy  output  1  high during the init sweep; requests are ignored while high
erroAcesso  output  1  one-cycle pulse: rd and we were both asserted in the same cycle

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-low (reset_n).
  - Every flop except the storage array clears immediately on reset_n=0.
- Reset values:
  - dataOutMem=0.
  - dataValid=0, writeAck=0, erroAcesso=0.
  - busy=1.
  - FSM=INIT, sweep pointer=0.
- Storage array: no reset; contents are defined only by the INIT sweep.
- FSM states: INIT, IDLE.
- INIT:
  - Each cycle, write INIT_VALUE to array[ptr], then ptr++.
  - When ptr = 2^ADDR_W-1 is written, go to IDLE on the same edge; busy drops the following cycle.
  - Sweep takes exactly 2^ADDR_W cycles after reset release (16 by default).
  - rd/we during INIT are ignored: no dataValid, no writeAck, no erroAcesso, no array change.
- IDLE, rd=1 and we=0:
  - On edge N, dataOutMem <= array[endMem].
  - dataValid=1 during cycle N+1 only.
  - Read latency = 1 cycle.
- IDLE, we=1 and rd=0:
  - On edge N, array[endMem] <= dataInMem.
  - writeAck=1 during cycle N+1 only.
  - dataOutMem holds its previous value.
- IDLE, rd=1 and we=1:
  - No array write; dataOutMem holds.
  - erroAcesso=1 for one cycle; dataValid and writeAck stay 0.
- IDLE, rd=0 and we=0: outputs hold, pulses are 0.
- Back-to-back accesses:
  - Strobes held high for k cycles yield k consecutive operations and k consecutive pulse cycles; there is no edge detection.
  - Write to A on edge N then read of A on edge N+1: the read returns the new data (array written before the read sample).
  - Read and write to the same address in the same cycle is an erroAcesso case, not a bypass.
- Address width: endMem is exactly ADDR_W bits, so every address is valid; no out-of-range handling.
- Reset mid-operation: any reset_n=0 pulse, in INIT or IDLE, returns to INIT with ptr=0 and re-runs the full sweep. In-flight pulses are dropped.
- dataOutMem is never combinational from the array; it is always a registered output.

Decomposition:
- Shared package (memoria_pkg): DATA_W/ADDR_W defaults, FSM state enum {INIT, IDLE}, INIT_VALUE default.
- One sub-module is natural: memoria_array, a plain 2^ADDR_W x DATA_W synchronous single-port storage with write enable and registered read.
- memoria_dados contains the FSM, sweep counter, arbitration and pulse generation.

Test Plan:
- Release reset_n at cycle 0, drive rd=1 addr 3 during cycles 0-15 -> busy=1 for 16 cycles, no dataValid; first IDLE read of addr 3 returns 8'h00 with dataValid one cycle later.
- IDLE: we=1 addr 4'h5 data 8'hA7, then rd=1 addr 4'h5 next cycle -> writeAck pulse after the write; dataValid with dataOutMem=8'hA7 after the read.
- Write 8'h11..8'h1F/8'h10 to all 16 addresses, then read all 16 back to back -> 16 consecutive dataValid cycles with matching data; address 4'hF does not wrap into 4'h0.
- rd=1 and we=1 together, addr 4'h2, data 8'hFF, after addr 2 holds 8'h3C -> erroAcesso one cycle; later read of addr 2 returns 8'h3C; dataOutMem unchanged at the error.
- Pulse reset_n low for 1 cycle mid-way through a write burst -> outputs clear immediately, busy=1 for 16 cycles; previously written addr reads back 8'h00.
- Parameter run DATA_W=16, ADDR_W=3, INIT_VALUE=16'hBEEF -> 8-cycle sweep; every address reads back 16'hBEEF.
